fpdiv_result_stage: RTL and testbench

- Registered output stage directly downstream of the combinational single-precision divider (fpdiv).
- Captures the dividend/divisor pair together with fpdiv's raw quotient.
- Overrides the quotient for IEEE-754 special operands (NaN, inf, zero, denormal) and raises the invalid and divide-by-zero flags.
- Delivers results over a valid/ready handshake with a 2-entry skid buffer, so fpdiv's combinational path is cut from the consumer.

---
 rtl/fpdiv_pkg.sv | 12 +
 rtl/fp_classify.sv | 23 ++
 rtl/fpdiv_result_stage.sv | 79 +++++++
 tb/tb_fpdiv_result_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg: shared operand classes, result record and IEEE-754 single constants.
package fpdiv_pkg;
    typedef enum logic [2:0] {FP_NORMAL, FP_ZERO, FP_INF, FP_QNAN, FP_SNAN} fp_class_t;
    typedef struct packed {
        logic [31:0] result;
        logic        nv;
        logic        dz;
    } fp_result_t;
    localparam logic [7:0]  FP_EXP_MAX      = 8'hFF;
    localparam logic [31:0] FP_POS_INF      = 32'h7F80_0000;
    localparam logic [31:0] FP_QNAN_DEFAULT = 32'h7FC0_0000;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: sorts one IEEE single operand into its class; denormals become zero when FTZ=1.
module fp_classify
    import fpdiv_pkg::*;
#(
    parameter bit FTZ = 1'b1
) (
    input  logic [31:0] x,
    output fp_class_t   cls,
    output logic        sign
);
    logic [7:0]  e;
    logic [22:0] f;
    assign e    = x[30:23];
    assign f    = x[22:0];
    assign sign = x[31];
    always_comb begin
        cls = FP_NORMAL;
        if (e == FP_EXP_MAX)
            cls = (f == '0) ? FP_INF : (f[22] ? FP_QNAN : FP_SNAN);
        else if (e == '0)
            cls = (f == '0 || FTZ) ? FP_ZERO : FP_NORMAL;
    end
endmodule

// File: rtl/fpdiv_result_stage.sv
// fpdiv_result_stage: special-operand override of the fpdiv quotient, delivered through a 2-entry skid buffer.
module fpdiv_result_stage
    import fpdiv_pkg::*;
#(
    parameter logic [31:0] QNAN = FP_QNAN_DEFAULT,
    parameter bit          FTZ  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [31:0] quotient,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_nv,
    output logic        flag_dz
);
    fp_class_t   ca, cb;
    logic        sa, sb, sign, a_nan, b_nan;
    logic [31:0] inf_r, zero_r;
    fp_result_t  nxt, main_q, skid_q;
    logic        main_v, skid_v, accept, emit;

    fp_classify #(.FTZ(FTZ)) u_a (.x(dividend), .cls(ca), .sign(sa));
    fp_classify #(.FTZ(FTZ)) u_b (.x(divisor),  .cls(cb), .sign(sb));

    assign sign   = sa ^ sb;
    assign a_nan  = ca == FP_QNAN || ca == FP_SNAN;
    assign b_nan  = cb == FP_QNAN || cb == FP_SNAN;
    assign inf_r  = {sign, FP_POS_INF[30:0]};
    assign zero_r = {sign, 31'h0};

    always_comb begin
        nxt = '{result: quotient, nv: 1'b0, dz: 1'b0};
        if (a_nan || b_nan)
            nxt = '{result: QNAN, nv: ca == FP_SNAN || cb == FP_SNAN, dz: 1'b0};
        else if ((ca == FP_ZERO && cb == FP_ZERO) || (ca == FP_INF && cb == FP_INF))
            nxt = '{result: QNAN, nv: 1'b1, dz: 1'b0};
        else if (ca == FP_INF)
            nxt = '{result: inf_r, nv: 1'b0, dz: 1'b0};
        else if (cb == FP_ZERO)
            nxt = '{result: inf_r, nv: 1'b0, dz: 1'b1};
        else if (ca == FP_ZERO || cb == FP_INF)
            nxt = '{result: zero_r, nv: 1'b0, dz: 1'b0};
    end

    assign in_ready  = ~skid_v;
    assign accept    = in_valid && in_ready;
    assign emit      = main_v && out_ready;
    assign out_valid = main_v;
    assign result    = main_q.result;
    assign flag_nv   = main_q.nv;
    assign flag_dz   = main_q.dz;

    // accept is impossible while the skid entry is full, so refill from skid never races an input
    always_ff @(posedge clk) begin
        if (reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (!main_v || emit) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                main_v <= accept;
                if (accept) main_q <= nxt;
            end
        end else if (accept) begin
            skid_q <= nxt;
            skid_v <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fpdiv_result_stage.sv
// tb_fpdiv_result_stage: directed checks of override priority, skid-buffer ordering and reset.
module tb_fpdiv_result_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag_nv;
    logic        flag_dz;
    int          errors = 0;
    int          checks = 0;

    fpdiv_result_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_nv(flag_nv), .flag_dz(flag_dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
        dividend = a;
        divisor  = b;
        quotient = q;
        in_valid = 1'b1;
    endtask

    task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] er, input logic env, input logic edz);
        out_ready = 1'b1;
        drive(a, b, q);
        tick();
        in_valid = 1'b0;
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        chk({tag, "_result"}, result, er);
        chk({tag, "_nv"}, {31'h0, flag_nv}, {31'h0, env});
        chk({tag, "_dz"}, {31'h0, flag_dz}, {31'h0, edz});
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {30'h0, flag_nv, flag_dz}, 32'h0);

        xfer("one_by_two", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000, 1'b0, 1'b0);
        xfer("pos_div0",   32'h3F80_0000, 32'h0000_0000, 32'h1234_5678, 32'h7F80_0000, 1'b0, 1'b1);
        xfer("neg_div0",   32'hBF80_0000, 32'h0000_0000, 32'h1234_5678, 32'hFF80_0000, 1'b0, 1'b1);
        xfer("zero_zero",  32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 32'h7FC0_0000, 1'b1, 1'b0);
        xfer("snan_a",     32'h7F80_0001, 32'h3F80_0000, 32'h1234_5678, 32'h7FC0_0000, 1'b1, 1'b0);
        xfer("qnan_a",     32'h7FC0_0000, 32'h3F80_0000, 32'h1234_5678, 32'h7FC0_0000, 1'b0, 1'b0);
        xfer("snan_b",     32'h0000_0000, 32'hFF80_0001, 32'h1234_5678, 32'h7FC0_0000, 1'b1, 1'b0);
        xfer("inf_inf",    32'h7F80_0000, 32'h7F80_0000, 32'h1234_5678, 32'h7FC0_0000, 1'b1, 1'b0);
        xfer("inf_fin",    32'h7F80_0000, 32'hC000_0000, 32'h1234_5678, 32'hFF80_0000, 1'b0, 1'b0);
        xfer("denorm_a",   32'h0000_0001, 32'h3F80_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0);
        xfer("denorm_b",   32'h3F80_0000, 32'h8000_0001, 32'h1234_5678, 32'hFF80_0000, 1'b0, 1'b1);
        xfer("fin_inf",    32'h3F80_0000, 32'h7F80_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0);
        xfer("negzero",    32'h8000_0000, 32'h3F80_0000, 32'h1234_5678, 32'h8000_0000, 1'b0, 1'b0);
        tick();
        chk("drained_valid", {31'h0, out_valid}, 32'h0);

        out_ready = 1'b0;
        drive(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000);
        tick();
        chk("bp_a_main", result, 32'h3F00_0000);
        chk("bp_a_ready", {31'h0, in_ready}, 32'h1);
        drive(32'hBF80_0000, 32'h0000_0000, 32'h1234_5678);
        tick();
        chk("bp_b_ready", {31'h0, in_ready}, 32'h0);
        chk("bp_b_hold", result, 32'h3F00_0000);
        drive(32'h4040_0000, 32'h3F80_0000, 32'h4040_0000);
        tick();
        chk("bp_c_held", {31'h0, in_ready}, 32'h0);
        chk("bp_a_still", result, 32'h3F00_0000);
        chk("bp_a_valid", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        tick();
        chk("bp_b_out", result, 32'hFF80_0000);
        chk("bp_b_dz", {31'h0, flag_dz}, 32'h1);
        chk("bp_b_valid", {31'h0, out_valid}, 32'h1);
        chk("bp_ready_up", {31'h0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        chk("bp_c_out", result, 32'h4040_0000);
        chk("bp_c_dz", {31'h0, flag_dz}, 32'h0);
        chk("bp_c_valid", {31'h0, out_valid}, 32'h1);
        tick();
        chk("bp_empty", {31'h0, out_valid}, 32'h0);

        out_ready = 1'b0;
        drive(32'h3F80_0000, 32'h0000_0000, 32'h0);
        tick();
        drive(32'h0000_0000, 32'h0000_0000, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("full_ready", {31'h0, in_ready}, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_ready", {31'h0, in_ready}, 32'h1);
        chk("mid_rst_result", result, 32'h0);
        chk("mid_rst_flags", {30'h0, flag_nv, flag_dz}, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("post_rst_idle", {31'h0, out_valid}, 32'h0);
        xfer("post_rst", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000, 1'b0, 1'b0);
        tick();
        chk("post_rst_drain", {31'h0, out_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
